// File: rtl/seq_pkg.sv
// Shared definitions for the seq_gen serial pattern transmitter and its peers.
package seq_pkg;

  // State encoding for the transmitter FSM.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_GAP   = ST_GAP,
    S_DONE  = ST_DONE
  } seq_state_t;

  // Default test pattern, shared with the seq_det benches.
  localparam logic [4:0] SEQ_PAT_10010 = 5'b10010;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that stops at zero and flags it.
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Load wins over decrement; decrement saturates at zero (never wraps).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts a latched pattern out MSB first,
// repeated a number of times with an optional run of idle zero-bits between
// repetitions.
//
// Handshake: start is a request that is only honoured while the FSM sits in
// IDLE or DONE; there is no ready output, so a start in SHIFT/GAP is simply
// dropped. seq_valid qualifies seq_data on every cycle it is high.
module seq_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic [GAP_W-1:0] gap_in,
  output logic             seq_data,
  output logic             seq_valid,
  output logic             busy,
  output logic             done,
  output seq_state_t       dbg_state,
  output logic [CNT_W-1:0] dbg_rep_left,
  output logic [GAP_W-1:0] dbg_gap_left
);

  localparam int IDX_W = $clog2(PAT_W);

  seq_state_t state_q, state_d;

  logic [PAT_W-1:0] pat_q;
  logic [GAP_W-1:0] gap_q;
  logic             latch;

  logic             idx_load, idx_dec, idx_zero;
  logic [IDX_W-1:0] idx_val, idx_cnt, idx_m1;
  logic             rep_load, rep_dec, rep_zero;
  logic [CNT_W-1:0] rep_val;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_val;

  logic nxt_data, nxt_valid, nxt_busy, nxt_done;

  // Bit index of the bit currently on seq_data.
  seq_down_cnt #(.W(IDX_W)) u_idx_cnt (
    .clk(clk), .rst_n(rst_n), .load(idx_load), .load_val(idx_val),
    .dec(idx_dec), .cnt(idx_cnt), .zero(idx_zero)
  );

  // Repetitions still to send after the current one.
  seq_down_cnt #(.W(CNT_W)) u_rep_cnt (
    .clk(clk), .rst_n(rst_n), .load(rep_load), .load_val(rep_val),
    .dec(rep_dec), .cnt(dbg_rep_left), .zero(rep_zero)
  );

  // Gap cycles still to spend after the current one.
  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst_n(rst_n), .load(gap_load), .load_val(gap_val),
    .dec(gap_dec), .cnt(dbg_gap_left), .zero(gap_zero)
  );

  assign idx_m1    = idx_cnt - 1'b1;
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Pattern and gap length are captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      gap_q <= '0;
    end else if (latch) begin
      pat_q <= pat_in;
      gap_q <= gap_in;
    end
  end

  // Next-state, counter control and next-output decode.
  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    nxt_data  = 1'b0;
    nxt_valid = 1'b0;
    idx_load  = 1'b0;
    idx_val   = IDX_W'(PAT_W - 1);
    idx_dec   = 1'b0;
    rep_load  = 1'b0;
    rep_val   = '0;
    rep_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_val   = '0;
    gap_dec   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_SHIFT;
            latch     = 1'b1;
            nxt_data  = pat_in[PAT_W-1];
            nxt_valid = 1'b1;
            idx_load  = 1'b1;
            rep_load  = 1'b1;
            // rep_in of 0 behaves as a single repetition.
            rep_val   = (rep_in == '0) ? '0 : rep_in - 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (!idx_zero) begin
            idx_dec   = 1'b1;
            nxt_data  = pat_q[idx_m1];
            nxt_valid = 1'b1;
          end else if (rep_zero) begin
            state_d = S_DONE;
          end else if (gap_q != '0) begin
            // Counter holds remaining gap cycles after the current one.
            state_d  = S_GAP;
            gap_load = 1'b1;
            gap_val  = gap_q - 1'b1;
          end else begin
            idx_load  = 1'b1;
            rep_dec   = 1'b1;
            nxt_data  = pat_q[PAT_W-1];
            nxt_valid = 1'b1;
          end
        end
        S_GAP: begin
          if (gap_zero) begin
            state_d   = S_SHIFT;
            idx_load  = 1'b1;
            rep_dec   = 1'b1;
            nxt_data  = pat_q[PAT_W-1];
            nxt_valid = 1'b1;
          end else begin
            gap_dec = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    nxt_busy = (state_d == S_SHIFT) || (state_d == S_GAP);
    nxt_done = (state_d == S_DONE);
  end

  // Registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_data  <= 1'b0;
      seq_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      seq_data  <= nxt_data;
      seq_valid <= nxt_valid;
      busy      <= nxt_busy;
      done      <= nxt_done;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: per-cycle comparison of
// {seq_data, seq_valid, busy, done} against a stream model.
module tb_seq_gen;
  import seq_pkg::*;

  localparam int PAT_W = 5;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_in;
  logic [CNT_W-1:0] rep_in;
  logic [GAP_W-1:0] gap_in;
  logic             seq_data, seq_valid, busy, done;
  seq_state_t       dbg_state;
  logic [CNT_W-1:0] dbg_rep_left;
  logic [GAP_W-1:0] dbg_gap_left;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle output tuples {seq_data, seq_valid, busy, done}.
  logic [3:0] exp_q[$];

  seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pat_in(pat_in), .rep_in(rep_in), .gap_in(gap_in),
    .seq_data(seq_data), .seq_valid(seq_valid), .busy(busy), .done(done),
    .dbg_state(dbg_state), .dbg_rep_left(dbg_rep_left),
    .dbg_gap_left(dbg_gap_left)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream model: R = max(rep,1) copies of the pattern MSB first, gap idle
  // zero-bits between copies (busy high), then one done cycle.
  task automatic build_exp(input logic [PAT_W-1:0] p, input int rep,
                           input int gap);
    int r_tot;
    r_tot = (rep == 0) ? 1 : rep;
    for (int r = 0; r < r_tot; r++) begin
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({p[i], 3'b110});
      if (r < r_tot - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endtask

  // Driver: request a stream; call at a negative edge.
  task automatic launch(input logic [PAT_W-1:0] p, input int rep,
                        input int gap);
    start  = 1'b1;
    pat_in = p;
    rep_in = CNT_W'(rep);
    gap_in = GAP_W'(gap);
    exp_q.delete();
    build_exp(p, rep, gap);
  endtask

  // Observe up to n cycles of the expected stream; while busy, scramble the
  // inputs and throw in stray start pulses, which must be ignored.
  task automatic play(input int n);
    logic [3:0] e;
    for (int k = 0; k < n && exp_q.size() > 0; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("stream", {28'd0, seq_data, seq_valid, busy, done}, {28'd0, e});
      start  = e[1] ? 1'($urandom_range(0, 1)) : 1'b0;
      pat_in = PAT_W'($urandom);
      rep_in = CNT_W'($urandom);
      gap_in = GAP_W'($urandom);
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check(tag, {28'd0, seq_data, seq_valid, busy, done}, 32'd0);
  endtask

  initial begin
    logic [PAT_W-1:0] rp;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    pat_in = '0;
    rep_in = '0;
    gap_in = '0;
    #1;
    check("reset_outs", {28'd0, seq_data, seq_valid, busy, done}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(S_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single repetition, then a gap-free double, then a double with gap 3.
    launch(SEQ_PAT_10010, 1, 0); play(1000); expect_idle("idle_t1");
    launch(SEQ_PAT_10010, 2, 0); play(1000); expect_idle("idle_t2");
    launch(SEQ_PAT_10010, 2, 3); play(1000); expect_idle("idle_t3");

    // rep=0 acts as one repetition.
    launch(5'b11001, 0, 0); play(1000); expect_idle("idle_t4");

    // Abort on the 3rd bit of rep 2, with start also raised (abort wins).
    launch(SEQ_PAT_10010, 2, 0);
    play(PAT_W + 3);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("abort_outs", {28'd0, seq_data, seq_valid, busy, done}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(S_IDLE));
    abort = 1'b0;
    launch(SEQ_PAT_10010, 1, 0); play(1000); expect_idle("idle_t5");

    // Asynchronous reset during the first gap cycle.
    launch(SEQ_PAT_10010, 2, 3);
    play(PAT_W + 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {28'd0, seq_data, seq_valid, busy, done}, 32'd0);
    exp_q.delete();
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    launch(SEQ_PAT_10010, 1, 0); play(1000); expect_idle("idle_t6");

    // Back-to-back streams: start raised during each done cycle.
    launch(SEQ_PAT_10010, 1, 1); play(1000);
    launch(5'b11001, 2, 1);      play(1000);
    launch(5'b10110, 3, 0);      play(1000);
    expect_idle("idle_t7");

    // Randomized streams, sometimes chained straight off the done cycle.
    repeat (20) begin
      rp = PAT_W'($urandom);
      launch(rp, $urandom_range(0, 3), $urandom_range(0, 3));
      play(1000);
      if ($urandom_range(0, 1) == 1) expect_idle("idle_rand");
    end
    expect_idle("idle_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
